// File: rtl/priority_scan_encoder.sv
// Sequential priority scan encoder: captures a request vector and emits the index
// of every set bit, one per accepted output beat, lowest-first or highest-first.
module priority_scan_encoder #(
  parameter int  WIDTH     = 8,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  output logic [IDX_W-1:0] outIdx,
  output logic             outValid,
  input  logic             outReady,
  output logic             outLast,
  output logic             outNone,
  output logic [IDX_W:0]   outCnt
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_SCAN = 1'b1;
  localparam logic [WIDTH-1:0] ONE_VEC = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             none_q, none_d;
  logic             live_q, live_d;

  logic             scan_s;
  logic             single_s;
  logic [IDX_W-1:0] pick_s;
  logic [WIDTH-1:0] pick_mask_s;

  // Last hit wins, so the walk direction decides which end has priority.
  function automatic logic [IDX_W-1:0] pick_index(input logic [WIDTH-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        idx = vec[i] ? IDX_W'(i) : idx;
      end else begin
        idx = vec[WIDTH-1-i] ? IDX_W'(WIDTH-1-i) : idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] vec);
    logic [IDX_W:0] sum;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum = sum + {{IDX_W{1'b0}}, vec[i]};
    end
    return sum;
  endfunction

  // Outputs decode registered state only; live_q holds inReady low until reset has released.
  always_comb begin
    scan_s      = (state_q == ST_SCAN);
    pick_s      = pick_index(pending_q);
    pick_mask_s = ONE_VEC << pick_s;
    single_s    = (pending_q != '0) && ((pending_q & (pending_q - ONE_VEC)) == '0);
    inReady     = live_q && !scan_s;
    outValid    = scan_s;
    outIdx      = scan_s ? pick_s : '0;
    outLast     = scan_s && (none_q || single_s);
    outNone     = scan_s && none_q;
    outCnt      = scan_s ? cnt_q : '0;
  end

  // Next-state logic: capture in IDLE, retire one bit per accepted beat in SCAN.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    none_d    = none_q;
    live_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (inValid && live_q) begin
          pending_d = inData;
          cnt_d     = popcount(inData);
          none_d    = (inData == '0);
          state_d   = ST_SCAN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (outReady) begin
          pending_d = pending_q & ~pick_mask_s;
          if (outLast) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            none_d  = 1'b0;
          end else begin
            state_d = ST_SCAN;
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
        cnt_d     = '0;
        none_d    = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      none_q    <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      none_q    <= none_d;
      live_q    <= live_d;
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Self-checking bench: three builds (8/LSB-first, 8/MSB-first, 16/LSB-first) checked
// beat by beat against a set-bit-list reference model.
module tb_priority_scan_encoder;

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0]  in_data_a, in_data_b;
  logic [15:0] in_data_c;
  logic        in_valid_a, in_valid_b, in_valid_c;
  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic        out_ready_a, out_ready_b, out_ready_c;
  logic        out_last_a, out_last_b, out_last_c;
  logic        out_none_a, out_none_b, out_none_c;
  logic [2:0]  out_idx_a, out_idx_b;
  logic [3:0]  out_idx_c;
  logic [3:0]  out_cnt_a, out_cnt_b;
  logic [4:0]  out_cnt_c;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
    .clk(clk), .rst_n(rst_n), .inData(in_data_a), .inValid(in_valid_a), .inReady(in_ready_a),
    .outIdx(out_idx_a), .outValid(out_valid_a), .outReady(out_ready_a), .outLast(out_last_a),
    .outNone(out_none_a), .outCnt(out_cnt_a));

  priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
    .clk(clk), .rst_n(rst_n), .inData(in_data_b), .inValid(in_valid_b), .inReady(in_ready_b),
    .outIdx(out_idx_b), .outValid(out_valid_b), .outReady(out_ready_b), .outLast(out_last_b),
    .outNone(out_none_b), .outCnt(out_cnt_b));

  priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb16 (
    .clk(clk), .rst_n(rst_n), .inData(in_data_c), .inValid(in_valid_c), .inReady(in_ready_c),
    .outIdx(out_idx_c), .outValid(out_valid_c), .outReady(out_ready_c), .outLast(out_last_c),
    .outNone(out_none_c), .outCnt(out_cnt_c));

  task automatic set_in(input int sel, input logic [15:0] data, input logic valid);
    case (sel)
      0:       begin in_data_a = data[7:0]; in_valid_a = valid; end
      1:       begin in_data_b = data[7:0]; in_valid_b = valid; end
      default: begin in_data_c = data;      in_valid_c = valid; end
    endcase
  endtask

  task automatic set_ready(input int sel, input logic r);
    case (sel)
      0:       out_ready_a = r;
      1:       out_ready_b = r;
      default: out_ready_c = r;
    endcase
  endtask

  // Packed view: {inReady, outValid, outLast, outNone, outCnt[4:0], outIdx[3:0]}
  task automatic observe(input int sel, output logic [12:0] obs);
    case (sel)
      0: obs = {in_ready_a, out_valid_a, out_last_a, out_none_a, 1'b0, out_cnt_a, 1'b0, out_idx_a};
      1: obs = {in_ready_b, out_valid_b, out_last_b, out_none_b, 1'b0, out_cnt_b, 1'b0, out_idx_b};
      default: obs = {in_ready_c, out_valid_c, out_last_c, out_none_c, out_cnt_c, out_idx_c};
    endcase
  endtask

  // Send one vector and check every beat against the list of set-bit positions.
  task automatic run_vec(input int sel, input logic [15:0] vec, input bit rnd, input bit keep,
                         input string tag);
    int          w;
    int          idxs[$];
    int          total;
    int          beat;
    int          cyc;
    bit          r;
    logic [12:0] obs;
    logic [12:0] exp;
    w = (sel == 2) ? 16 : 8;
    for (int i = 0; i < w; i++) if (vec[i]) idxs.push_back(i);
    total = idxs.size();
    if (sel == 1) idxs.reverse();
    if (total == 0) idxs.push_back(0);
    cyc = 0;
    observe(sel, obs);
    while (obs[12] !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      observe(sel, obs);
      cyc++;
    end
    n_checks++;
    if (obs[12] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready_wait: got %b, expected 1", tag, obs[12]);
      return;
    end
    set_in(sel, vec, 1'b1);
    set_ready(sel, 1'b0);
    @(posedge clk); #1;
    if (!keep) set_in(sel, 16'($urandom), 1'b0);
    beat = 0;
    cyc  = 0;
    while (beat < idxs.size() && cyc < 200) begin
      observe(sel, obs);
      exp = {1'b0, 1'b1, (beat == idxs.size() - 1), (total == 0), 5'(total), 4'(idxs[beat])};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s vec=%h beat %0d cycle %0d: got %h, expected %h", tag, vec, beat, cyc, obs, exp);
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      set_ready(sel, r);
      @(posedge clk); #1;
      if (r) beat++;
      cyc++;
    end
    n_checks++;
    if (beat < idxs.size()) begin
      n_fail++;
      $display("FAIL %s beat_timeout: got %0d beats, expected %0d", tag, beat, idxs.size());
    end
    observe(sel, obs);
    n_checks++;
    if (obs !== 13'h1000) begin
      n_fail++;
      $display("FAIL %s bubble vec=%h: got %h, expected %h", tag, vec, obs, 13'h1000);
    end
    set_ready(sel, 1'b0);
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_in(s, 16'h0000, 1'b0);
      set_ready(s, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      observe(s, obs);
      n_checks++;
      if (obs !== 13'h0000) begin
        n_fail++;
        $display("FAIL reset_hold inst %0d: got %h, expected %h", s, obs, 13'h0000);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      observe(s, obs);
      n_checks++;
      if (obs !== 13'h1000) begin
        n_fail++;
        $display("FAIL reset_release inst %0d: got %h, expected %h", s, obs, 13'h1000);
      end
    end
  endtask

  task automatic test_one_hot();
    for (int i = 0; i < 8; i++) run_vec(0, 16'(1 << i), 1'b0, 1'b0, "one_hot");
  endtask

  task automatic test_pattern();
    run_vec(0, 16'h00A6, 1'b0, 1'b0, "pattern_lsb");
    run_vec(1, 16'h00A6, 1'b0, 1'b0, "pattern_msb");
  endtask

  task automatic test_zero();
    run_vec(0, 16'h0000, 1'b0, 1'b0, "zero_lsb");
    run_vec(1, 16'h0000, 1'b0, 1'b0, "zero_msb");
    run_vec(2, 16'h0000, 1'b1, 1'b0, "zero_w16");
  endtask

  task automatic test_full_toggle();
    for (int k = 0; k < 3; k++) run_vec(0, 16'h00FF, 1'b1, 1'b0, "full_toggle");
  endtask

  task automatic test_mid_reset();
    logic [12:0] obs;
    logic [12:0] exp;
    run_vec(0, 16'h0001, 1'b0, 1'b0, "pre_reset");
    set_in(0, 16'h00F0, 1'b1);
    set_ready(0, 1'b1);
    @(posedge clk); #1;
    set_in(0, 16'h0000, 1'b0);
    for (int b = 0; b < 2; b++) begin
      observe(0, obs);
      exp = {1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 4'(4 + b)};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL mid_reset beat %0d: got %h, expected %h", b, obs, exp);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    observe(0, obs);
    n_checks++;
    if (obs !== 13'h0000) begin
      n_fail++;
      $display("FAIL mid_reset_flush: got %h, expected %h", obs, 13'h0000);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    observe(0, obs);
    n_checks++;
    if (obs !== 13'h1000) begin
      n_fail++;
      $display("FAIL mid_reset_release: got %h, expected %h", obs, 13'h1000);
    end
    set_ready(0, 1'b0);
    run_vec(0, 16'h0002, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_wide();
    run_vec(2, 16'h8001, 1'b0, 1'b0, "wide_8001");
    run_vec(2, 16'hC3A5, 1'b1, 1'b0, "wide_c3a5");
  endtask

  // inValid held high throughout: each vector of N=2 bits takes N+1 cycles.
  task automatic test_back_to_back();
    int t0;
    t0 = cyc_cnt;
    for (int k = 0; k < 3; k++) run_vec(0, 16'h000C, 1'b0, 1'b1, "back_to_back");
    set_in(0, 16'h0000, 1'b0);
    n_checks++;
    if (cyc_cnt - t0 !== 9) begin
      n_fail++;
      $display("FAIL back_to_back_period: got %0d cycles, expected %0d", cyc_cnt - t0, 9);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) run_vec(0, 16'($urandom & 32'h00FF), 1'b1, 1'b0, "rand_lsb");
    for (int k = 0; k < 12; k++) run_vec(1, 16'($urandom & $urandom & 32'h00FF), 1'b1, 1'b0, "rand_msb");
    for (int k = 0; k < 12; k++) run_vec(2, 16'($urandom & $urandom), 1'b1, 1'b0, "rand_w16");
  endtask

  initial begin
    test_reset();
    test_one_hot();
    test_pattern();
    test_zero();
    test_full_toggle();
    test_back_to_back();
    test_mid_reset();
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
